// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative RV32M multiply unit (MUL/MULH/MULHSU/MULHU)
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request a multiply, sampled only when not busy
//   op     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   A, B   multiplicand / multiplier
//   busy   operation in progress
//   done   one-cycle pulse, result valid
//   result low (MUL) or high (MULH*) half of the 2*SIZE product
module shift_add_multiplier #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] result
);
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        op_q;
    logic              neg;
    logic [SIZE-1:0]   mcand;
    logic [SIZE-1:0]   hi;
    logic [SIZE-1:0]   lo;
    logic              sa;
    logic              sb;
    logic [SIZE:0]     sum;
    logic [2*SIZE-1:0] prod;

    always_comb begin
        sa   = (op == 2'b01 || op == 2'b10) && A[SIZE-1];
        sb   = (op == 2'b01) && B[SIZE-1];
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        // Sign restored on the full product so the carry crosses into the high half
        prod = neg ? ~{hi, lo} + (2*SIZE)'(1) : {hi, lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg    <= 1'b0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (state == RUN) begin
            if (cnt == CW'(SIZE)) begin
                state  <= FIN;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= (op_q == 2'b00) ? prod[SIZE-1:0] : prod[2*SIZE-1:SIZE];
            end else begin
                // {carry,hi,lo} shifted right one place after the conditional add
                hi  <= sum[SIZE:1];
                lo  <= {sum[0], lo[SIZE-1:1]};
                cnt <= cnt + CW'(1);
            end
        end else begin
            // IDLE and FIN both accept a new request (FIN gives back-to-back issue)
            done  <= 1'b0;
            busy  <= start;
            state <= start ? RUN : IDLE;
            if (start) begin
                op_q  <= op;
                neg   <= sa ^ sb;
                mcand <= sa ? -A : A;
                lo    <= sb ? -B : B;
                hi    <= '0;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: random and directed checks against a 64-bit arithmetic model
module tb_shift_add_multiplier;
    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = '0;
    logic [SIZE-1:0] A = '0;
    logic [SIZE-1:0] B = '0;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] result;
    int              n_chk = 0;
    int              n_fail = 0;

    shift_add_multiplier #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        x = (o == 2'd1 || o == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        y = (o == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p = x * y;
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < SIZE + 6) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({tag, " latency"}, n, SIZE + 1);
        chk({tag, " result"}, result, ref_mul(o, a, b));
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, bad, pulses;
        logic [31:0] pick [4];
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(2'd0, 32'd500, 32'hFFFFFE3E, "mul neg");
        chk("mul neg const", result, 32'hFFFC9118);
        run_op(2'd1, 32'd500, 32'hFFFFFE3E, "mulh neg");
        chk("mulh neg const", result, 32'hFFFFFFFF);
        run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu max");
        chk("mulhu max const", result, 32'hFFFFFFFE);
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul max");
        run_op(2'd1, 32'h80000000, 32'h80000000, "mulh minmin");
        chk("mulh minmin const", result, 32'h40000000);
        run_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        run_op(2'd1, 32'd0, 32'hFFFFFFF0, "mulh zero");

        // start pulsed mid-run must be ignored, busy must not drop early
        @(negedge clk);
        op = 2'd0; A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; bad = 0;
        while (!done && n < SIZE + 6) begin
            @(posedge clk); #1;
            n++;
            if (!done && !busy) bad++;
            start = (n == 5);
            A = 32'd7; B = 32'd6;
        end
        start = 1'b0;
        chk("ignore latency", n, SIZE + 1);
        chk("ignore result", result, 32'd15);
        chk("ignore busy gap", bad, 0);

        // start held across the done cycle: back-to-back issue
        @(posedge clk); #1;
        op = 2'd3; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        op = 2'd0; A = 32'd2; B = 32'd21;
        wait_done(n);
        chk("b2b first latency", n, SIZE + 1);
        chk("b2b first result", result, 32'hFFFFFFFE);
        chk("b2b busy@done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b accepted busy", 32'(busy), 32'd1);
        chk("b2b accepted done", 32'(done), 32'd0);
        wait_done(n);
        chk("b2b second latency", n, SIZE + 1);
        chk("b2b second result", result, 32'd42);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        op = 2'd0; A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        repeat (SIZE + 4) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort no done", pulses, 0);
        run_op(2'd0, 32'd2, 32'd3, "after abort");

        for (int i = 0; i < 40; i++) begin
            pick[0] = 32'd0; pick[1] = 32'h80000000; pick[2] = 32'hFFFFFFFF; pick[3] = $urandom;
            run_op(2'($urandom), ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : $urandom,
                   ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : $urandom, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
